// File: rtl/register_write_queue.sv
// Register write decoder between the SPI slave and the voice engine.
// Global control writes are applied at once; parameter RAM writes are queued and drained on granted slots.
module register_write_queue #(
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_VOICES = 32
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_RegisterWriteEnable,
    input  logic [15:0]                   i_RegisterWriteNumber,
    input  logic [15:0]                   i_RegisterWriteValue,
    input  logic                          i_WriteAllowed,
    output logic                          o_ParamWriteEnable,
    output logic [ADDR_WIDTH-1:0]         o_ParamAddress,
    output logic [15:0]                   o_ParamValue,
    output logic [NUM_VOICES-1:0]         o_NoteOnMask,
    output logic                          o_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_FifoLevel
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [15:0] REG_MASK_LO   = 16'h8000;
    localparam logic [15:0] REG_MASK_HI   = 16'h8001;
    localparam logic [15:0] REG_OVF_CLEAR = 16'h8002;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [15:0]           value;
    } entry_t;

    // Storage and state
    entry_t                mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  enable_last_q;
    logic                  reset_block_q, reset_block_d;
    logic                  param_we_q;
    entry_t                param_q;
    logic [NUM_VOICES-1:0] mask_q, mask_d;
    logic                  overflow_q, overflow_d;

    // Decode and queue control
    logic                  accept;
    logic                  is_param;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [31:0]           mask_wide;

    // NOTE: every combinational output gets a default before any branch, so no path can infer a latch.
    always_comb begin
        // A strobe held over reset release stays blocked until enable has been seen low.
        accept        = i_RegisterWriteEnable && !enable_last_q && !reset_block_q;
        reset_block_d = reset_block_q && i_RegisterWriteEnable;
        is_param      = accept && !i_RegisterWriteNumber[15];

        full  = (level_q == LVL_W'(FIFO_DEPTH));
        empty = (level_q == '0);
        pop   = !empty && i_WriteAllowed;
        push  = is_param && (!full || pop);
        drop  = is_param && full && !pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        level_d = level_q + LVL_W'(push) - LVL_W'(pop);

        // Mask halves are edited in a 32-bit view; voices beyond NUM_VOICES fall off on truncation.
        mask_wide = 32'(mask_q);
        if (accept && (i_RegisterWriteNumber == REG_MASK_LO)) begin
            mask_wide[15:0] = i_RegisterWriteValue;
        end
        if (accept && (i_RegisterWriteNumber == REG_MASK_HI)) begin
            mask_wide[31:16] = i_RegisterWriteValue;
        end
        mask_d = NUM_VOICES'(mask_wide);

        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (accept && (i_RegisterWriteNumber == REG_OVF_CLEAR) && i_RegisterWriteValue[0]) begin
            overflow_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            enable_last_q <= 1'b0;
            reset_block_q <= 1'b1;
            param_we_q    <= 1'b0;
            param_q       <= '0;
            mask_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            enable_last_q <= i_RegisterWriteEnable;
            reset_block_q <= reset_block_d;
            param_we_q    <= pop;
            mask_q        <= mask_d;
            overflow_q    <= overflow_d;
            if (pop) begin
                param_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // NOTE: queue storage has no reset; the level and pointers alone define which entries are valid.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr:  i_RegisterWriteNumber[ADDR_WIDTH-1:0],
                                 value: i_RegisterWriteValue};
        end
    end

    assign o_ParamWriteEnable = param_we_q;
    assign o_ParamAddress     = param_q.addr;
    assign o_ParamValue       = param_q.value;
    assign o_NoteOnMask       = mask_q;
    assign o_Overflow         = overflow_q;
    assign o_FifoLevel        = level_q;

endmodule

// File: tb/tb_register_write_queue.sv
// Scoreboard bench for register_write_queue: a queue-based reference model predicts parameter writes,
// level, overflow and mask; a monitor checks every presented write and the status outputs each cycle.
module tb_register_write_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 10;
    localparam int NV    = 32;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          wa  = 1'b0;
    logic [15:0]   num = '0;
    logic [15:0]   val = '0;
    logic          pwe;
    logic [AW-1:0] paddr;
    logic [15:0]   pval;
    logic [NV-1:0] mask;
    logic          ovf;
    logic [LW-1:0] level;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   value;
    } wr_t;

    wr_t         m_fifo[$];
    wr_t         sb[$];
    logic [31:0] m_mask    = '0;
    logic        m_ovf     = 1'b0;
    logic        m_prev    = 1'b0;
    logic        m_blocked = 1'b1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc[$];
    bit rand_wa = 1'b0;

    register_write_queue #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_WIDTH(AW),
        .NUM_VOICES(NV)
    ) dut (
        .i_Clock              (clk),
        .i_Reset              (rst),
        .i_RegisterWriteEnable(en),
        .i_RegisterWriteNumber(num),
        .i_RegisterWriteValue (val),
        .i_WriteAllowed       (wa),
        .o_ParamWriteEnable   (pwe),
        .o_ParamAddress       (paddr),
        .o_ParamValue         (pval),
        .o_NoteOnMask         (mask),
        .o_Overflow           (ovf),
        .o_FifoLevel          (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: a command queue drained one entry per granted cycle, mask and overflow as plain state.
    always @(posedge clk or posedge rst) begin : model
        bit  acc;
        bit  do_pop;
        wr_t e;
        if (rst) begin
            m_fifo.delete();
            sb.delete();
            m_mask    = '0;
            m_ovf     = 1'b0;
            m_prev    = 1'b0;
            m_blocked = 1'b1;
        end else begin
            acc    = en && !m_prev && !m_blocked;
            do_pop = (m_fifo.size() > 0) && wa;
            if (do_pop) sb.push_back(m_fifo.pop_front());
            if (acc) begin
                if (!num[15]) begin
                    e.addr  = num[AW-1:0];
                    e.value = val;
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(e);
                    else m_ovf = 1'b1;
                end else if (num == 16'h8000) begin
                    m_mask[15:0] = val;
                end else if (num == 16'h8001) begin
                    m_mask[31:16] = val;
                end else if (num == 16'h8002 && val[0]) begin
                    m_ovf = 1'b0;
                end
            end
            m_prev    = en;
            m_blocked = m_blocked && en;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a parameter write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (!rst) begin
            if (pwe) begin
                pulse_cnt++;
                pulse_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    check("unexpected_param_write", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("param_addr", 64'(paddr), 64'(e.addr));
                    check("param_value", 64'(pval), 64'(e.value));
                end
            end
            check("fifo_level", 64'(level), 64'(m_fifo.size()));
            check("overflow", 64'(ovf), 64'(m_ovf));
            check("note_on_mask", 64'(mask), 64'(m_mask[NV-1:0]));
        end
    end

    task automatic send(input logic [15:0] n, input logic [15:0] v, input int hold);
        @(negedge clk);
        en  = 1'b1;
        num = n;
        val = v;
        if (rand_wa) wa = ($urandom_range(0, 1) == 1);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            if (rand_wa) wa = ($urandom_range(0, 1) == 1);
        end
        @(negedge clk);
        en = 1'b0;
        if (rand_wa) wa = ($urandom_range(0, 1) == 1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin : stimulus
        int base;
        int acc_cyc;
        int lat;
        logic [LW-1:0] lvl_before;
        logic [15:0]   n;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_pwe", 64'(pwe), 64'd0);
        check("reset_level", 64'(level), 64'd0);
        check("reset_overflow", 64'(ovf), 64'd0);
        check("reset_mask", 64'(mask), 64'd0);
        check("reset_addr", 64'(paddr), 64'd0);

        // Held strobe yields exactly one write, two cycles after the rising edge.
        wa = 1'b1;
        base = pulse_cnt;
        @(negedge clk);
        pulse_cyc.delete();
        en = 1'b1; num = 16'h0123; val = 16'hBEEF; acc_cyc = cyc;
        repeat (7) @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        check("t1_pulse_count", 64'(pulse_cnt - base), 64'd1);
        lat = (pulse_cyc.size() > 0) ? pulse_cyc[0] - acc_cyc : -1;
        check("t1_latency", 64'(lat), 64'd2);
        check("t1_addr", 64'(paddr), 64'h123);
        check("t1_value", 64'(pval), 64'hBEEF);

        // Fill with no grant, then drain back-to-back in order.
        wa = 1'b0;
        base = pulse_cnt;
        for (int k = 0; k < DEPTH; k++) send(16'(k), 16'h1000 + 16'(k), 1);
        check("t2_level_full", 64'(level), 64'd8);
        check("t2_no_strobe", 64'(pulse_cnt - base), 64'd0);
        @(negedge clk);
        pulse_cyc.delete();
        wa = 1'b1;
        repeat (12) @(negedge clk);
        check("t2_pulse_count", 64'(pulse_cnt - base), 64'd8);
        lat = (pulse_cyc.size() == 8) ? pulse_cyc[7] - pulse_cyc[0] : -1;
        check("t2_back_to_back", 64'(lat), 64'd7);
        check("t2_level_empty", 64'(level), 64'd0);
        check("t2_last_value", 64'(pval), 64'h1007);

        // Overflow on a full queue, then explicit clear.
        wa = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(16'h0020 + 16'(k), 16'h2000 + 16'(k), 1);
        send(16'h03FF, 16'hDEAD, 1);
        check("t3_overflow_set", 64'(ovf), 64'd1);
        check("t3_level_held", 64'(level), 64'd8);
        base = pulse_cnt;
        wa = 1'b1;
        repeat (12) @(negedge clk);
        check("t3_drain_count", 64'(pulse_cnt - base), 64'd8);
        check("t3_last_addr", 64'(paddr), 64'h027);
        send(16'h8002, 16'h0001, 1);
        check("t3_overflow_clear", 64'(ovf), 64'd0);

        // Note-on mask halves and an ignored global register.
        send(16'h8000, 16'hA5A5, 1);
        check("t4_mask_lo", 64'(mask), 64'h0000_A5A5);
        send(16'h8001, 16'h0F0F, 1);
        check("t4_mask_hi", 64'(mask), 64'h0F0F_A5A5);
        lvl_before = level;
        send(16'h8003, 16'hFFFF, 1);
        check("t4_mask_unchanged", 64'(mask), 64'h0F0F_A5A5);
        check("t4_level_unchanged", 64'(level), 64'(lvl_before));

        // Push into a full queue in the same cycle as a pop.
        wa = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(16'h0040 + 16'(k), 16'h4000 + 16'(k), 1);
        base = pulse_cnt;
        @(negedge clk);
        wa = 1'b1; en = 1'b1; num = 16'h0177; val = 16'h7777;
        @(negedge clk);
        en = 1'b0;
        check("t5_level_stays_full", 64'(level), 64'd8);
        check("t5_no_overflow", 64'(ovf), 64'd0);
        repeat (12) @(negedge clk);
        check("t5_drain_count", 64'(pulse_cnt - base), 64'd9);
        check("t5_last_addr", 64'(paddr), 64'h177);
        check("t5_last_value", 64'(pval), 64'h7777);

        // Randomized traffic: sparse grants first to exercise overflow, then dense.
        rand_wa = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) n = {1'b0, 15'($urandom)};
            else n = 16'h8000 + 16'($urandom_range(0, 4));
            if (i < 120) begin
                send(n, 16'($urandom), 1);
                wa = ($urandom_range(0, 7) == 0);
            end else begin
                send(n, 16'($urandom), $urandom_range(1, 3));
            end
        end
        rand_wa = 1'b0;
        wa = 1'b1;
        repeat (20) @(negedge clk);
        check("rand_scoreboard_drained", 64'(sb.size()), 64'd0);
        check("rand_level_empty", 64'(level), 64'd0);

        // Asynchronous reset with entries queued and a strobe in flight.
        wa = 1'b0;
        send(16'h8000, 16'h1234, 1);
        for (int k = 0; k < 5; k++) send(16'h0060 + 16'(k), 16'h6000 + 16'(k), 1);
        @(negedge clk);
        en = 1'b1; num = 16'h0055; val = 16'h5555;
        #2 rst = 1'b1;
        #1;
        check("arst_pwe", 64'(pwe), 64'd0);
        check("arst_addr", 64'(paddr), 64'd0);
        check("arst_value", 64'(pval), 64'd0);
        check("arst_mask", 64'(mask), 64'd0);
        check("arst_overflow", 64'(ovf), 64'd0);
        check("arst_level", 64'(level), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wa = 1'b1;
        base = pulse_cnt;
        repeat (5) @(negedge clk);
        check("arst_held_strobe_ignored", 64'(pulse_cnt - base), 64'd0);
        check("arst_level_after", 64'(level), 64'd0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        check("arst_fresh_edge_count", 64'(pulse_cnt - base), 64'd1);
        check("arst_fresh_edge_addr", 64'(paddr), 64'h055);
        check("arst_fresh_edge_value", 64'(pval), 64'h5555);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
